// File: rtl/wb_sram_master_pkg.sv
// Shared types and defaults for the Wishbone SRAM block master.
//   state_t         : block-master FSM states
//   *_DEF           : default widths/timeout, shared with the SRAM responder
//   SEL_ALL         : full-word byte select for the default data width
package wb_sram_master_pkg;

  localparam int unsigned ADDR_WD_DEF     = 8;
  localparam int unsigned DATA_WD_DEF     = 32;
  localparam int unsigned LEN_WD_DEF      = 9;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;
  localparam int unsigned SEL_WD_DEF      = DATA_WD_DEF / 8;

  localparam logic [SEL_WD_DEF-1:0] SEL_ALL = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage : wb_sram_master_pkg

// File: rtl/wb_ack_timer.sv
// Ack watchdog: counts cycles a strobe waits for an acknowledge.
//   wb_clk_i  in  clock
//   rst_n     in  async active-low reset
//   load_i    in  clear the count (strobe about to be raised)
//   en_i      in  strobe high and no ack this cycle
//   expire_c  out combinational: this un-acked cycle is the TIMEOUT_CYC-th one
module wb_ack_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic wb_clk_i,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CNT_WD = $clog2(TIMEOUT_CYC);

  logic [CNT_WD-1:0] cnt_q;

  // Count holds at the limit; the owner leaves ISSUE on expiry anyway.
  assign expire_c = en_i && (cnt_q == CNT_WD'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_c) begin
      cnt_q <= cnt_q + CNT_WD'(1);
    end
  end

endmodule : wb_ack_timer

// File: rtl/wb_sram_block_master.sv
// Wishbone classic-cycle block master: moves cmd_len_i words between local
// valid/ready streams and the SRAM responder, one single-beat cycle per word.
//   wb_clk_i, rst_n              clock, async active-low reset
//   cmd_valid_i/cmd_ready_o      command handshake (ready only in IDLE)
//   cmd_write_i/addr_i/len_i     direction, start word address, word count
//   wr_data_i/valid_i/ready_o    write stream (ready only while fetching a word)
//   rd_data_o/valid_o/ready_i    read stream, one-word registered buffer
//   busy_o, done_o, err_o        status; done/err are one-cycle pulses
//   wb_*                         Wishbone initiator port
module wb_sram_block_master
  import wb_sram_master_pkg::*;
#(
  parameter  int unsigned ADDR_WD     = ADDR_WD_DEF,
  parameter  int unsigned DATA_WD     = DATA_WD_DEF,
  parameter  int unsigned LEN_WD      = LEN_WD_DEF,
  parameter  int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int unsigned SEL_WD      = DATA_WD / 8
) (
  input  logic               wb_clk_i,
  input  logic               rst_n,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_write_i,
  input  logic [ADDR_WD-1:0] cmd_addr_i,
  input  logic [LEN_WD-1:0]  cmd_len_i,
  input  logic [DATA_WD-1:0] wr_data_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  output logic [DATA_WD-1:0] rd_data_o,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [ADDR_WD-1:0] wb_adr_o,
  output logic [DATA_WD-1:0] wb_dat_o,
  output logic [SEL_WD-1:0]  wb_sel_o,
  input  logic [DATA_WD-1:0] wb_dat_i,
  input  logic               wb_ack_i
);

  localparam logic [SEL_WD-1:0] SEL_ONES = '1;

  state_t             state_q, state_d;
  logic [LEN_WD-1:0]  rem_q, rem_d;
  logic [ADDR_WD-1:0] adr_d;
  logic               we_d;
  logic [DATA_WD-1:0] wdat_d, rdat_d;
  logic               done_d, err_d;
  logic               issue_d;
  logic               tmr_load_c, tmr_en_c, tmr_expire_c;

  // Ack watchdog, restarted each time a strobe is about to be raised.
  assign tmr_load_c = (state_d == ISSUE) && (state_q != ISSUE);
  assign tmr_en_c   = (state_q == ISSUE) && !wb_ack_i;

  wb_ack_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ack_timer (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .load_i   (tmr_load_c),
    .en_i     (tmr_en_c),
    .expire_c (tmr_expire_c)
  );

  // Next-state and next-register values; all outputs are registered from these.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    adr_d   = wb_adr_o;
    we_d    = wb_we_o;
    wdat_d  = wb_dat_o;
    rdat_d  = rd_data_o;
    done_d  = 1'b0;
    err_d   = 1'b0;
    issue_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d = cmd_addr_i;
          we_d  = cmd_write_i;
          rem_d = cmd_len_i;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else if (cmd_write_i) begin
            state_d = FETCH;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      FETCH: begin
        if (wr_valid_i) begin
          wdat_d  = wr_data_i;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // Ack takes priority over a simultaneous timeout.
        if (wb_ack_i) begin
          adr_d = wb_adr_o + ADDR_WD'(1);
          rem_d = rem_q - LEN_WD'(1);
          if (!wb_we_o) begin
            rdat_d  = wb_dat_i;
            state_d = DRAIN;
          end else if (rem_q == LEN_WD'(1)) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end else if (tmr_expire_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      DRAIN: begin
        // The read buffer holds one word; no new cycle until it is taken.
        if (rd_ready_i) begin
          state_d = (rem_q == '0) ? DONE : ISSUE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) begin
      done_d = 1'b1;
    end
    issue_d = (state_d == ISSUE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      cmd_ready_o <= 1'b1;
      wr_ready_o  <= 1'b0;
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cmd_ready_o <= (state_d == IDLE);
      wr_ready_o  <= (state_d == FETCH);
      rd_data_o   <= rdat_d;
      rd_valid_o  <= (state_d == DRAIN);
      busy_o      <= (state_d != IDLE);
      done_o      <= done_d;
      err_o       <= err_d;
      wb_cyc_o    <= issue_d;
      wb_stb_o    <= issue_d;
      wb_we_o     <= we_d;
      wb_adr_o    <= adr_d;
      wb_dat_o    <= wdat_d;
      wb_sel_o    <= issue_d ? SEL_ONES : '0;
    end
  end

endmodule : wb_sram_block_master

// File: tb/tb_wb_sram_block_master.sv
// Scoreboard bench for wb_sram_block_master with a 1-cycle-ack SRAM responder.
module tb_wb_sram_block_master;

  logic        wb_clk_i = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [7:0]  cmd_addr_i;
  logic [8:0]  cmd_len_i;
  logic [31:0] wr_data_i;
  logic        wr_valid_i, wr_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, rd_ready_i;
  logic        busy_o, done_o, err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_sram_block_master dut (
    .wb_clk_i    (wb_clk_i),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .wr_data_i   (wr_data_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i)
  );

  // ---------------- SRAM responder model ----------------
  bit [31:0] sram [256];
  bit        resp_en = 1'b1;

  always @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= '0;
    end else begin
      wb_ack_i <= resp_en && wb_cyc_o && wb_stb_o && !wb_ack_i;
      if (resp_en && wb_cyc_o && wb_stb_o && !wb_ack_i) begin
        if (wb_we_o) sram[wb_adr_o] <= wb_dat_o;
        else         wb_dat_i       <= sram[wb_adr_o];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [7:0]  adr;
    logic        we;
    logic [31:0] dat;
    logic [7:0]  run;
  } beat_t;

  bit [31:0]   ref_mem [256];
  beat_t       exp_beat_q[$];
  logic [31:0] exp_rd_q[$];
  int          exp_evt_q[$];   // 0 = done pulse, 1 = err pulse
  logic [31:0] wr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  bit wr_rand = 1'b0;
  bit rd_rand = 1'b0;
  int stall_left = 0;

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Write stream driver: offers queued words, pops on observed handshake.
  initial begin
    bit hs;
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    forever begin
      @(negedge wb_clk_i);
      hs = wr_valid_i && wr_ready_o && rst_n;
      @(posedge wb_clk_i);
      #1;
      if (hs && wr_q.size() > 0) void'(wr_q.pop_front());
      if (wr_q.size() > 0) begin
        wr_valid_i = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_data_i  = wr_q[0];
      end else begin
        wr_valid_i = 1'b0;
      end
    end
  end

  // Read stream sink: optional forced stall, optional random back-pressure.
  initial begin
    rd_ready_i = 1'b1;
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (stall_left > 0) begin
        rd_ready_i = 1'b0;
        if (rd_valid_o) stall_left--;
      end else begin
        rd_ready_i = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: compares every bus cycle, read word and status pulse.
  bit          stb_prev = 1'b0, rdv_prev = 1'b0, rdy_prev = 1'b0;
  int          run = 0, run_exp = 0, stb_rise_cyc = 0;
  logic [31:0] rd_hold = '0;

  always @(negedge wb_clk_i) begin
    beat_t b;
    if (!rst_n) begin
      stb_prev = 1'b0;
      rdv_prev = 1'b0;
      run      = 0;
    end else begin
      if (wb_stb_o && !stb_prev) begin
        stb_rise_cyc = cyc_cnt;
        run_exp      = 2;
        if (exp_beat_q.size() == 0) begin
          fail_msg("unexpected_bus_cycle");
        end else begin
          b = exp_beat_q.pop_front();
          run_exp = int'(b.run);
          chk("wb_adr", 64'(wb_adr_o), 64'(b.adr));
          chk("wb_we", 64'(wb_we_o), 64'(b.we));
          chk("wb_cyc_sel", 64'({wb_cyc_o, wb_sel_o}), 64'(5'h1F));
          chk("no_stb_with_rd_valid", 64'(rd_valid_o), 64'd0);
          if (b.we) chk("wb_dat_o", 64'(wb_dat_o), 64'(b.dat));
        end
      end
      if (wb_stb_o) run++;
      if (!wb_stb_o && stb_prev) begin
        chk("stb_len", 64'(run), 64'(run_exp));
        run = 0;
      end

      if (rd_valid_o && !rdv_prev)
        chk("rd_latency", 64'(cyc_cnt - stb_rise_cyc), 64'd2);
      if (rd_valid_o && rdv_prev && !rdy_prev)
        chk("rd_hold", 64'(rd_data_o), 64'(rd_hold));
      if (rd_valid_o && rd_ready_i) begin
        if (exp_rd_q.size() == 0) fail_msg("unexpected_rd_word");
        else chk("rd_data", 64'(rd_data_o), 64'(exp_rd_q.pop_front()));
      end
      rdv_prev = rd_valid_o;
      rdy_prev = rd_ready_i;
      rd_hold  = rd_data_o;

      if (done_o || err_o) begin
        if (exp_evt_q.size() == 0) fail_msg("unexpected_done_err");
        else chk("done_err", 64'({err_o, done_o}),
                 (exp_evt_q.pop_front() == 1) ? 64'd2 : 64'd1);
      end
      stb_prev = wb_stb_o;
    end
  end

  task automatic flush_all();
    exp_beat_q.delete();
    exp_rd_q.delete();
    exp_evt_q.delete();
    wr_q.delete();
  endtask

  // Queue the expected behaviour of a command, then hand it to the DUT.
  task automatic issue(input logic we, input logic [7:0] addr, input int len,
                       input bit tmo, input logic [31:0] base, input bit seq);
    int n = 0;
    logic [7:0] a;
    logic [31:0] d;
    while (!cmd_ready_o && n < 1000) begin
      @(posedge wb_clk_i);
      #1;
      n++;
    end
    if (n >= 1000) fail_msg("cmd_ready_wait_timeout");
    if (len == 0) begin
      exp_evt_q.push_back(0);
    end else if (tmo) begin
      d = seq ? base : $urandom;
      exp_beat_q.push_back('{adr: addr, we: we, dat: d, run: 8'd16});
      if (we) wr_q.push_back(d);
      exp_evt_q.push_back(1);
    end else begin
      for (int i = 0; i < len; i++) begin
        a = addr + 8'(i);
        d = seq ? base + 32'(i) : $urandom;
        exp_beat_q.push_back('{adr: a, we: we, dat: d, run: 8'd2});
        if (we) begin
          ref_mem[a] = d;
          wr_q.push_back(d);
        end else begin
          exp_rd_q.push_back(ref_mem[a]);
        end
      end
      exp_evt_q.push_back(0);
    end
    cmd_valid_i = 1'b1;
    cmd_write_i = we;
    cmd_addr_i  = addr;
    cmd_len_i   = 9'(len);
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
    if (len == 0) begin
      chk("len0_done_next_cycle", 64'(done_o), 64'd1);
      chk("len0_no_stb", 64'(wb_stb_o), 64'd0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_beat_q.size() != 0 || exp_rd_q.size() != 0 || exp_evt_q.size() != 0 ||
            wr_q.size() != 0 || !cmd_ready_o) && n < 3000) begin
      @(negedge wb_clk_i);
      n++;
    end
    repeat (2) @(negedge wb_clk_i);
    if (n >= 3000) begin
      fail_msg({name, "_drain_timeout"});
      flush_all();
    end
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_status", 64'({busy_o, done_o, err_o, wr_ready_o, rd_valid_o}), 64'd0);
    chk("rst_bus_ctl", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'd0);
    chk("rst_bus_adr_dat", 64'({wb_adr_o, wb_dat_o}), 64'd0);
    chk("rst_rd_data", 64'(rd_data_o), 64'd0);
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    @(posedge wb_clk_i);
    #1;

    // Directed: write block, read it back, wrap + stall, timeout, zero length.
    issue(1'b1, 8'h10, 4, 1'b0, 32'h0000_00A0, 1'b1);
    wait_drain("write_4");
    issue(1'b0, 8'h10, 4, 1'b0, 32'h0, 1'b0);
    wait_drain("read_4");
    stall_left = 5;
    issue(1'b0, 8'hFE, 3, 1'b0, 32'h0, 1'b0);
    wait_drain("read_wrap_stall");
    resp_en = 1'b0;
    issue(1'b0, 8'h40, 2, 1'b1, 32'h0, 1'b0);
    wait_drain("timeout");
    chk("timeout_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("timeout_not_busy", 64'(busy_o), 64'd0);
    resp_en = 1'b1;
    issue(1'b0, 8'h20, 0, 1'b0, 32'h0, 1'b0);
    wait_drain("len0");

    // Randomised blocks with stream back-pressure.
    wr_rand = 1'b1;
    rd_rand = 1'b1;
    for (int k = 0; k < 24; k++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 6), 1'b0, 32'h0, 1'b0);
      wait_drain("random");
    end
    wr_rand = 1'b0;
    rd_rand = 1'b0;

    // Reset in the middle of a write block.
    issue(1'b1, 8'h80, 4, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (!(wb_stb_o && exp_beat_q.size() <= 2) && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 500) fail_msg("mid_write_wait_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    chk("midrst_idle", 64'({cmd_ready_o, busy_o, done_o, err_o}), 64'h8);
    flush_all();
    repeat (2) @(negedge wb_clk_i);
    rst_n = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    @(posedge wb_clk_i);
    #1;
    issue(1'b0, 8'h10, 2, 1'b0, 32'h0, 1'b0);
    wait_drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_sram_block_master
